// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one on-chip memory port between two Avalon-MM masters.
// Read data returns through a fixed-latency tag pipeline to the issuing master.
module onchip_mem_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int BE_W    = 4,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic               prio;
  logic               req0, req1;
  logic               grant0, grant1;
  logic               rd_acc;
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_id;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // prio names the winner only when both request
  assign grant0 = ~reset & req0 & (~req1 | ~prio);
  assign grant1 = ~reset & req1 & (~req0 | prio);

  assign m0_waitrequest = reset | (req0 & ~grant0);
  assign m1_waitrequest = reset | (req1 & ~grant1);

  assign ram_chipselect = grant0 | grant1;
  assign ram_address    = grant1 ? m1_address    : m0_address;
  assign ram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign ram_write      = grant1 ? m1_write      : (grant0 & m0_write);
  assign ram_clken      = 1'b1;

  // a write wins over a read asserted in the same cycle
  assign rd_acc = (grant0 & m0_read & ~m0_write)
                | (grant1 & m1_read & ~m1_write);

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (grant0) begin
      prio <= 1'b1;
    end else if (grant1) begin
      prio <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= rd_acc;
      tag_id[0] <= grant1;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign m0_readdatavalid = ~reset & tag_v[LATENCY-1] & ~tag_id[LATENCY-1];
  assign m1_readdatavalid = ~reset & tag_v[LATENCY-1] &  tag_id[LATENCY-1];
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench: two arbiters (LATENCY 1 and 2) share stimulus, each with
// its own behavioural memory.
module tb_onchip_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [10:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;

  logic        wr0_a, wr1_a, rdv0_a, rdv1_a;
  logic [31:0] rd0_a, rd1_a;
  logic [10:0] addr_a;
  logic [3:0]  be_a;
  logic        cs_a, we_a, clken_a;
  logic [31:0] wd_a, q_a;

  logic        wr0_b, wr1_b, rdv0_b, rdv1_b;
  logic [31:0] rd0_b, rd1_b;
  logic [10:0] addr_b;
  logic [3:0]  be_b;
  logic        cs_b, we_b, clken_b;
  logic [31:0] wd_b, q1_b, q2_b;

  logic [31:0] mem_a [0:2047];
  logic [31:0] mem_b [0:2047];

  int checks = 0;
  int failures = 0;
  int i0, i1, g, pg, pa;

  onchip_mem_arbiter #(.LATENCY(1)) dut_a (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(wr0_a), .m0_readdata(rd0_a), .m0_readdatavalid(rdv0_a),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(wr1_a), .m1_readdata(rd1_a), .m1_readdatavalid(rdv1_a),
    .ram_address(addr_a), .ram_byteenable(be_a), .ram_chipselect(cs_a),
    .ram_write(we_a), .ram_writedata(wd_a), .ram_clken(clken_a),
    .ram_readdata(q_a)
  );

  onchip_mem_arbiter #(.LATENCY(2)) dut_b (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(wr0_b), .m0_readdata(rd0_b), .m0_readdatavalid(rdv0_b),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(wr1_b), .m1_readdata(rd1_b), .m1_readdatavalid(rdv1_b),
    .ram_address(addr_b), .ram_byteenable(be_b), .ram_chipselect(cs_b),
    .ram_write(we_b), .ram_writedata(wd_b), .ram_clken(clken_b),
    .ram_readdata(q2_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory A: unregistered q (1 clock); memory B: output register (2 clocks)
  always @(posedge clk) begin
    if (cs_a && clken_a) begin
      q_a <= mem_a[addr_a];
      if (we_a)
        for (int b = 0; b < 4; b++)
          if (be_a[b]) mem_a[addr_a][8*b +: 8] = wd_a[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (clken_b) q2_b <= q1_b;
    if (cs_b && clken_b) begin
      q1_b <= mem_b[addr_b];
      if (we_b)
        for (int b = 0; b < 4; b++)
          if (be_b[b]) mem_b[addr_b][8*b +: 8] = wd_b[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  initial begin
    q_a = 0; q1_b = 0; q2_b = 0;
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = 32'h1000_0000 + i;
      mem_b[i] = 32'h1000_0000 + i;
    end
    mem_a[5] = 32'hCAFEF00D;
    mem_b[5] = 32'hCAFEF00D;
    reset = 1;
    idle();
    m0_address = 0; m1_address = 0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = 0; m1_writedata = 0;
    tick();

    // reset forces stalls and idle memory port
    m0_read = 1; m1_read = 1; m1_write = 1;
    #1;
    chk("rst_wait0", wr0_a, 1);
    chk("rst_wait1", wr1_a, 1);
    chk("rst_cs", cs_a, 0);
    chk("rst_we", we_a, 0);
    chk("rst_rdv0", rdv0_a, 0);
    tick();
    reset = 0;
    idle();
    tick();

    // single uncontended read
    m0_read = 1; m0_address = 11'h005;
    #1;
    chk("t1_wait0", wr0_a, 0);
    chk("t1_cs", cs_a, 1);
    chk("t1_addr", 32'(addr_a), 32'h005);
    tick();
    idle();
    #1;
    chk("t1_rdv0_a", rdv0_a, 1);
    chk("t1_data_a", rd0_a, 32'hCAFEF00D);
    chk("t1_rdv1_a", rdv1_a, 0);
    chk("t1_rdv0_b_early", rdv0_b, 0);
    tick();
    chk("t1_rdv0_b", rdv0_b, 1);
    chk("t1_data_b", rd0_b, 32'hCAFEF00D);
    chk("t1_rdv0_a_done", rdv0_a, 0);

    // contention from reset: grants alternate starting with m0
    reset = 1;
    tick();
    reset = 0;
    i0 = 0; i1 = 0; g = 0;
    for (int c = 0; c <= 8; c++) begin
      m0_read = (c < 8);
      m1_read = (c < 8);
      m0_address = 11'(i0);
      m1_address = 11'(256 + i1);
      #1;
      if (c < 8) begin
        g = c % 2;
        chk($sformatf("t2_wait0_c%0d", c), wr0_a, (g != 0));
        chk($sformatf("t2_wait1_c%0d", c), wr1_a, (g != 1));
      end
      if (c > 0) begin
        pg = (c - 1) % 2;
        pa = (pg != 0) ? 256 + (c - 1) / 2 : (c - 1) / 2;
        chk($sformatf("t2_rdv0_c%0d", c), rdv0_a, (pg == 0));
        chk($sformatf("t2_rdv1_c%0d", c), rdv1_a, (pg == 1));
        chk($sformatf("t2_data_c%0d", c), (pg != 0) ? rd1_a : rd0_a,
            32'h1000_0000 + pa);
      end
      tick();
      if (c < 8) begin
        if (g == 0) i0++;
        else i1++;
      end
    end
    idle();

    // byte-lane writes from m1 then readback by m0
    m1_write = 1; m1_address = 11'h010;
    m1_writedata = 32'h11223344; m1_byteenable = 4'hF;
    #1;
    chk("t3_wait1", wr1_a, 0);
    chk("t3_we", we_a, 1);
    tick();
    m1_writedata = 32'hAABBCCDD; m1_byteenable = 4'h5;
    tick();
    idle();
    #1;
    chk("t3_rdv1_wr", rdv1_a, 0);
    m0_read = 1; m0_address = 11'h010;
    tick();
    idle();
    chk("t3_rdv0", rdv0_a, 1);
    chk("t3_data", rd0_a, 32'h11BB33DD);

    // read and write together count as a write
    m0_read = 1; m0_write = 1; m0_address = 11'h020;
    m0_writedata = 32'h5A5A5A5A; m0_byteenable = 4'hF;
    #1;
    chk("t4_we", we_a, 1);
    tick();
    idle();
    #1;
    chk("t4_rdv0_wr", rdv0_a, 0);
    m0_read = 1;
    tick();
    idle();
    chk("t4_rdv0", rdv0_a, 1);
    chk("t4_data", rd0_a, 32'h5A5A5A5A);

    // reset while a LATENCY=2 read is in flight
    m0_read = 1; m0_address = 11'h005;
    tick();
    idle();
    reset = 1;
    #1;
    chk("t5_rdv0_b_rst", rdv0_b, 0);
    chk("t5_rdv0_a_rst", rdv0_a, 0);
    chk("t5_wait0_b", wr0_b, 1);
    chk("t5_wait1_b", wr1_b, 1);
    tick();
    reset = 0;
    #1;
    chk("t5_rdv0_b_drop", rdv0_b, 0);
    chk("t5_rdv1_b_drop", rdv1_b, 0);
    m0_read = 1; m1_read = 1; m0_address = 11'h005; m1_address = 11'h100;
    #1;
    chk("t5_prio_w0", wr0_b, 0);
    chk("t5_prio_w1", wr1_b, 1);
    tick();
    m0_read = 0;
    #1;
    chk("t5_rdv0_lat1", rdv0_b, 0);
    chk("t5_m1_grant", wr1_b, 0);
    tick();
    idle();
    #1;
    chk("t5_rdv0_b", rdv0_b, 1);
    chk("t5_data0_b", rd0_b, 32'hCAFEF00D);
    chk("t5_rdv1_b_early", rdv1_b, 0);
    tick();
    chk("t5_rdv1_b", rdv1_b, 1);
    chk("t5_data1_b", rd1_b, 32'h1000_0100);

    // pointer holds through idle cycles after an m1 grant
    m0_read = 1; m0_address = 11'h001;
    tick();
    idle();
    m1_read = 1; m1_address = 11'h101;
    #1;
    chk("t6_m1_alone", wr1_a, 0);
    tick();
    idle();
    tick();
    tick();
    tick();
    m0_read = 1; m1_read = 1;
    #1;
    chk("t6_wait0", wr0_a, 0);
    chk("t6_wait1", wr1_a, 1);
    tick();
    #1;
    chk("t6_next_wait0", wr0_a, 1);
    chk("t6_next_wait1", wr1_a, 0);
    tick();
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
